sha256_msg_sender: RTL and testbench
====================================

// Module: sha256_msg_sender
// PURPOSE
//  Synthesizable host-side initiator for the SHA-256 manager stream interface.
//  - Takes a command (base address, length in words).
//  - Reads the message words from a word-wide memory with fixed 1-cycle read latency.
//  - Streams the words with a last flag into the manager's data port, then accepts the
//    returned digest and presents it on a result port.
//  - Replaces the simulation file reader in hardware builds.
// PARAMETERS
//  DATA_W    SHA_IF_DATA_W    width of one message word on the manager interface
//  DIG_W     SHA256_DIGEST_W  digest width
//  ADDR_W    10               message memory word-address width
//  LEN_W     16               command length field width (words)
// PORTS
//  clk                   in   1       clock
//  rst                   in   1       synchronous reset, active-high
//  cmd_val               in   1       command valid
//  cmd_base_addr         in   ADDR_W  first word address
//  cmd_len_words         in   LEN_W   message length in words; 0 is treated as 1
//  cmd_rdy               out  1       command accepted when val&rdy
//  mem_rd_req_val        out  1       memory read strobe; memory always accepts
//  mem_rd_req_addr       out  ADDR_W  read address
//  mem_rd_resp_data      in   DATA_W  read data; valid exactly 1 cycle after the strobe
//  sender_dst_data_val   out  1       message word valid
//  sender_dst_data       out  DATA_W  message word
//  sender_dst_data_last  out  1       final word of the message
//  dst_sender_rdy        in   1       manager accepts the word
//  src_sender_digest_val in   1       digest valid from manager
//  src_sender_digest     in   DIG_W   digest
//  sender_src_digest_rdy out  1       digest accepted when val&rdy
//  res_val               out  1       result digest valid
//  res_digest            out  DIG_W   result digest
//  res_rdy               in   1       result consumer ready
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; FIFO empty; in-flight flag cleared.
//    A read response returning in the cycle after rst is discarded.
//  - FSM: IDLE -> STREAM -> WAIT_DIGEST -> RESULT -> IDLE.
//    - IDLE: cmd_rdy=1. On cmd handshake, latch addr and len (0 -> 1), clear issue/send counters.
//    - STREAM: issue reads, push responses into a 2-entry FIFO tagged with last, drive the
//      FIFO head on sender_dst_*. Exit when the word tagged last is handshaken.
//    - WAIT_DIGEST: sender_src_digest_rdy=1. Capture the digest on handshake; go to RESULT.
//    - RESULT: res_val=1 with res_digest held stable until res_rdy; then IDLE.
//  - Digest rdy is 0 in every other state, so a digest offered early is stalled, never lost.
//  - Read issue rule, evaluated each cycle:
//    - Issue while words remain to issue and (fifo_count + inflight - pop) < 2,
//      where pop = val & dst_sender_rdy.
//    - The FIFO never overflows. Sustained throughput is 1 word/cycle with rdy held high.
//  - Latency: cmd handshake in cycle 0 -> read strobe in cycle 1 -> sender_dst_data_val
//    in cycle 3 at the earliest.
//  - Words leave in address order: base, base+1, ... Addresses wrap modulo 2^ADDR_W.
//  - sender_dst_data/_last are held stable while val=1 and rdy=0. Valid never drops
//    without a handshake.
//  - Simultaneous FIFO push and pop in one cycle: count unchanged, order preserved.
//  - Exactly one word per message carries last=1. Length 1 gives a single word with last=1.
//  - Commands are not pipelined: the next cmd is accepted only after the result handshake.
// STRUCTURE
//  - Shared package sha256_defs: SHA_IF_DATA_W and SHA256_DIGEST_W (existing), plus a new
//    sha256_sender_state_e enum {IDLE, STREAM, WAIT_DIGEST, RESULT}.
//  - One sub-module, sha256_sender_fifo: 2-entry FIFO, width DATA_W+1 (data + last),
//    with push, pop, head and count outputs.
// TESTING
//  - Len 3 at base 0x3FE, mem[a]=a, rdy always 1 -> words 0x3FE, 0x3FF, 0x000 on
//    consecutive cycles; last only on the third word.
//  - Len 4, dst_sender_rdy toggles 1010... -> all 4 words in order; data stable while
//    stalled; no FIFO overflow; exactly one read per word.
//  - Len 0 -> one read, one word with last=1; digest 0xABCD...
//    returned on res_digest.
//  - Digest val asserted during STREAM -> sender_src_digest_rdy stays 0 until last word
//    handshaken; digest captured once.
//  - res_rdy held 0 for 5 cycles -> res_val/res_digest stable, cmd_rdy=0; after
//    res_rdy=1 -> IDLE, cmd_rdy=1.
//  - rst asserted for 1 cycle mid-STREAM with a read in flight -> outputs 0, FIFO empty,
//    stale response dropped; next cmd streams correctly.

Source files
------------

// File: rtl/sha256_defs.sv
// Shared SHA-256 interface widths and the message sender's state encoding.
package sha256_defs;

  localparam int SHA_IF_DATA_W   = 32;
  localparam int SHA256_DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STREAM      = 2'd1,
    WAIT_DIGEST = 2'd2,
    RESULT      = 2'd3
  } sha256_sender_state_e;

endpackage

// File: rtl/sha256_sender_fifo.sv
// Two-entry FIFO holding {last, data} between the message memory and the manager port.
module sha256_sender_fifo
  import sha256_defs::*;
#(
  parameter int W = SHA_IF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         rd_ptr;
  logic         wr_ptr;

  // The caller never pushes into a full FIFO nor pops an empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/sha256_msg_sender.sv
// Reads a message from word memory, streams it to the SHA-256 manager and returns the digest.
// Handshakes: a transfer happens on a rising edge where val and rdy are both 1; once val is
// raised it stays up with its payload unchanged until that transfer.
module sha256_msg_sender
  import sha256_defs::*;
#(
  parameter int DATA_W = SHA_IF_DATA_W,
  parameter int DIG_W  = SHA256_DIGEST_W,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_val,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [LEN_W-1:0]  cmd_len_words,
  output logic              cmd_rdy,
  output logic              mem_rd_req_val,
  output logic [ADDR_W-1:0] mem_rd_req_addr,
  input  logic [DATA_W-1:0] mem_rd_resp_data,
  output logic              sender_dst_data_val,
  output logic [DATA_W-1:0] sender_dst_data,
  output logic              sender_dst_data_last,
  input  logic              dst_sender_rdy,
  input  logic              src_sender_digest_val,
  input  logic [DIG_W-1:0]  src_sender_digest,
  output logic              sender_src_digest_rdy,
  output logic              res_val,
  output logic [DIG_W-1:0]  res_digest,
  input  logic              res_rdy,
  output logic [1:0]        dbg_state
);

  sha256_sender_state_e state;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  issue_left;
  logic              inflight;
  logic              inflight_last;
  logic [DIG_W-1:0]  digest_q;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_pop;
  logic              in_stream;
  logic              issue;
  logic [2:0]        occupancy;

  assign in_stream            = (state == STREAM);
  assign sender_dst_data_val  = in_stream && (fifo_count != 2'd0);
  assign sender_dst_data      = sender_dst_data_val ? fifo_head[DATA_W-1:0] : '0;
  assign sender_dst_data_last = sender_dst_data_val & fifo_head[DATA_W];
  assign fifo_pop             = sender_dst_data_val & dst_sender_rdy;

  // Slots already claimed next cycle: stored words plus the response on its way, minus the
  // word leaving now. Keeping this below 2 is what makes FIFO overflow impossible.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, fifo_pop};
  assign issue     = in_stream && (issue_left != '0) && (occupancy < 3'd2);

  assign mem_rd_req_val        = issue;
  assign mem_rd_req_addr       = rd_addr;
  assign cmd_rdy               = (state == IDLE) && !rst;
  assign sender_src_digest_rdy = (state == WAIT_DIGEST);
  assign res_val               = (state == RESULT);
  assign res_digest            = digest_q;
  assign dbg_state             = state;

  sha256_sender_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_rd_resp_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      digest_q      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_last <= (issue_left == LEN_W'(1));
        rd_addr       <= rd_addr + ADDR_W'(1);
        issue_left    <= issue_left - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (cmd_val) begin
            rd_addr    <= cmd_base_addr;
            issue_left <= (cmd_len_words == '0) ? LEN_W'(1) : cmd_len_words;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (fifo_pop && sender_dst_data_last) state <= WAIT_DIGEST;
        end
        WAIT_DIGEST: begin
          if (src_sender_digest_val) begin
            digest_q <= src_sender_digest;
            state    <= RESULT;
          end
        end
        RESULT: begin
          if (res_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sender.sv
// Directed bench for sha256_msg_sender: memory model, stream scoreboard and digest/result checks.
module tb_sha256_msg_sender;

  localparam int DATA_W = 32;
  localparam int DIG_W  = 256;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_val = 1'b0;
  logic [ADDR_W-1:0] cmd_base_addr = '0;
  logic [LEN_W-1:0]  cmd_len_words = '0;
  logic              cmd_rdy;
  logic              mem_rd_req_val;
  logic [ADDR_W-1:0] mem_rd_req_addr;
  logic [DATA_W-1:0] mem_rd_resp_data;
  logic              sender_dst_data_val;
  logic [DATA_W-1:0] sender_dst_data;
  logic              sender_dst_data_last;
  logic              dst_sender_rdy = 1'b0;
  logic              src_sender_digest_val = 1'b0;
  logic [DIG_W-1:0]  src_sender_digest = '0;
  logic              sender_src_digest_rdy;
  logic              res_val;
  logic [DIG_W-1:0]  res_digest;
  logic              res_rdy = 1'b0;
  logic [1:0]        dbg_state;

  sha256_msg_sender dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_val               (cmd_val),
    .cmd_base_addr         (cmd_base_addr),
    .cmd_len_words         (cmd_len_words),
    .cmd_rdy               (cmd_rdy),
    .mem_rd_req_val        (mem_rd_req_val),
    .mem_rd_req_addr       (mem_rd_req_addr),
    .mem_rd_resp_data      (mem_rd_resp_data),
    .sender_dst_data_val   (sender_dst_data_val),
    .sender_dst_data       (sender_dst_data),
    .sender_dst_data_last  (sender_dst_data_last),
    .dst_sender_rdy        (dst_sender_rdy),
    .src_sender_digest_val (src_sender_digest_val),
    .src_sender_digest     (src_sender_digest),
    .sender_src_digest_rdy (sender_src_digest_rdy),
    .res_val               (res_val),
    .res_digest            (res_digest),
    .res_rdy               (res_rdy),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W:0] exp_q[$];
  int rdy_mode = 0;   // 0: rdy low, 1: rdy high, 2: toggle 1010...
  int n_reads  = 0;
  int n_words  = 0;
  logic [21:0] salt = '0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {salt, a};
  endfunction

  // Memory with fixed one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_req_val) begin
      mem_rd_resp_data <= mem_word(mem_rd_req_addr);
      n_reads <= n_reads + 1;
    end else begin
      mem_rd_resp_data <= 32'hDEAD_BEEF;
    end
  end

  // Manager-side rdy driver and stream scoreboard; acts 1 time unit after each falling edge.
  initial begin
    logic            tog;
    logic            stalled;
    logic            seen_first;
    logic [DATA_W:0] held_word;
    logic [DATA_W:0] exp_w;
    tog = 1'b0;
    stalled = 1'b0;
    seen_first = 1'b0;
    held_word = '0;
    forever begin
      @(negedge clk);
      #1;
      case (rdy_mode)
        0:       dst_sender_rdy = 1'b0;
        1:       dst_sender_rdy = 1'b1;
        default: begin tog = ~tog; dst_sender_rdy = tog; end
      endcase
      if (rst) begin
        stalled = 1'b0;
        seen_first = 1'b0;
      end else begin
        if (stalled) begin
          check("valid_held", 256'(sender_dst_data_val), 256'(1));
          check("word_stable", 256'({sender_dst_data_last, sender_dst_data}), 256'(held_word));
        end
        if (rdy_mode == 1 && seen_first && exp_q.size() != 0)
          check("no_gap", 256'(sender_dst_data_val), 256'(1));
        stalled = 1'b0;
        if (sender_dst_data_val) begin
          if (dst_sender_rdy) begin
            n_words++;
            seen_first = 1'b1;
            if (exp_q.size() != 0) begin
              exp_w = exp_q.pop_front();
              check("word", 256'({sender_dst_data_last, sender_dst_data}), 256'(exp_w));
              if (exp_q.size() == 0) seen_first = 1'b0;
            end
          end else begin
            stalled = 1'b1;
            held_word = {sender_dst_data_last, sender_dst_data};
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(negedge clk);
    #3;
  endtask

  task automatic run_msg(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                         input int mode, input logic [DIG_W-1:0] dig, input bit early,
                         input int hold, input bit lat_chk);
    int n;
    int guard;
    int rd0;
    int w0;
    n = (len == '0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      exp_q.push_back({(i == n - 1), mem_word(a)});
    end
    rdy_mode = mode;
    rd0 = n_reads;
    w0 = n_words;
    check("idle_cmd_rdy", 256'(cmd_rdy), 256'(1));
    cmd_val = 1'b1;
    cmd_base_addr = base;
    cmd_len_words = len;
    if (early) begin
      src_sender_digest_val = 1'b1;
      src_sender_digest = dig;
    end
    nxt();
    cmd_val = 1'b0;
    if (lat_chk) begin
      check("lat_c1_strobe", 256'(mem_rd_req_val), 256'(1));
      check("lat_c1_addr", 256'(mem_rd_req_addr), 256'(base));
      check("lat_c1_no_word", 256'(sender_dst_data_val), 256'(0));
      nxt();
      check("lat_c2_no_word", 256'(sender_dst_data_val), 256'(0));
      nxt();
      check("lat_c3_word", 256'(sender_dst_data_val), 256'(1));
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      if (early) check("digest_rdy_stream", 256'(sender_src_digest_rdy), 256'(0));
      nxt();
      guard++;
    end
    check("stream_drained", 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    nxt();
    check("wait_state", 256'(dbg_state), 256'(2'd2));
    check("digest_rdy", 256'(sender_src_digest_rdy), 256'(1));
    src_sender_digest_val = 1'b1;
    src_sender_digest = dig;
    nxt();
    src_sender_digest = ~dig;
    check("res_val", 256'(res_val), 256'(1));
    check("res_digest", res_digest, dig);
    check("digest_rdy_after", 256'(sender_src_digest_rdy), 256'(0));
    for (int i = 0; i < hold; i++) begin
      nxt();
      check("hold_res_val", 256'(res_val), 256'(1));
      check("hold_res_digest", res_digest, dig);
      check("hold_cmd_rdy", 256'(cmd_rdy), 256'(0));
    end
    res_rdy = 1'b1;
    nxt();
    res_rdy = 1'b0;
    src_sender_digest_val = 1'b0;
    check("done_res_val", 256'(res_val), 256'(0));
    check("done_cmd_rdy", 256'(cmd_rdy), 256'(1));
    check("read_count", 256'(n_reads - rd0), 256'(n));
    check("word_count", 256'(n_words - w0), 256'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    rst = 1'b1;
    nxt();
    nxt();
    check("rst_cmd_rdy", 256'(cmd_rdy), 256'(0));
    check("rst_rd_val", 256'(mem_rd_req_val), 256'(0));
    check("rst_word_val", 256'(sender_dst_data_val), 256'(0));
    check("rst_res_val", 256'(res_val), 256'(0));
    check("rst_res_digest", res_digest, 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));
    rst = 1'b0;
    nxt();
    check("post_rst_cmd_rdy", 256'(cmd_rdy), 256'(1));
    check("post_rst_digest_rdy", 256'(sender_src_digest_rdy), 256'(0));

    // wrap across the top of memory, mem[a] = a
    salt = '0;
    run_msg(10'h3FE, 16'd3, 1, {8{32'h0123_4567}}, 1'b0, 0, 1'b1);

    // stalled manager with a digest offered during the stream
    salt = 22'h15A3C;
    run_msg(10'h100, 16'd4, 2, {8{32'hFEED_0042}}, 1'b1, 0, 1'b0);

    // zero length means one word; result consumer stalls for 5 cycles
    salt = 22'h0F0F0;
    run_msg(10'h055, 16'd0, 1, {16{16'hABCD}}, 1'b0, 5, 1'b0);

    // reset while a read is in flight
    salt = 22'h2A5A5;
    rdy_mode = 0;
    cmd_val = 1'b1;
    cmd_base_addr = 10'h010;
    cmd_len_words = 16'd8;
    nxt();
    cmd_val = 1'b0;
    check("rr_strobe", 256'(mem_rd_req_val), 256'(1));
    nxt();
    rst = 1'b1;
    nxt();
    check("rr_cmd_rdy_in_rst", 256'(cmd_rdy), 256'(0));
    check("rr_word_val", 256'(sender_dst_data_val), 256'(0));
    check("rr_rd_val", 256'(mem_rd_req_val), 256'(0));
    check("rr_state", 256'(dbg_state), 256'(0));
    rst = 1'b0;
    rdy_mode = 1;
    w0 = n_words;
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("rr_idle_word_val", 256'(sender_dst_data_val), 256'(0));
      check("rr_idle_rd_val", 256'(mem_rd_req_val), 256'(0));
    end
    check("rr_cmd_rdy", 256'(cmd_rdy), 256'(1));
    check("rr_no_stale_word", 256'(n_words - w0), 256'(0));

    salt = 22'h33333;
    run_msg(10'h200, 16'd2, 1, {4{64'h5555_AAAA_0F0F_F0F0}}, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
